// File: rtl/mux7_rr.sv
// Seven-to-one round-robin gatherer: merges seven channels into one tagged output stream.
// Latency: 1 cycle from input acceptance to out/out_valid; one word per cycle sustained.
// Backpressure: in_ready is held low while the output register is full and out_ready is low.
//
// Optional feature macro: FIXED_PRIO_EN
//   defined   -> fixed priority, channel 0 highest; the round-robin pointer is removed
//   undefined -> round-robin arbitration starting from rr_ptr (default)
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active-high
//   in0..in6   : channel data words (W bits)
//   in_valid   : per-channel request
//   in_ready   : per-channel accept, one-hot or zero
//   out        : registered output word
//   out_sel    : channel index of the word in out (0..6)
//   out_valid  : out/out_sel hold a valid word
//   out_ready  : downstream accepts out this cycle
module mux7_rr #(
    parameter int W   = 13,
    parameter int NCH = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in0,
    input  logic [W-1:0]   in1,
    input  logic [W-1:0]   in2,
    input  logic [W-1:0]   in3,
    input  logic [W-1:0]   in4,
    input  logic [W-1:0]   in5,
    input  logic [W-1:0]   in6,
    input  logic [NCH-1:0] in_valid,
    output logic [NCH-1:0] in_ready,
    output logic [W-1:0]   out,
    output logic [2:0]     out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    // Entry 7 is padding so a 3-bit index never leaves the array.
    logic [W-1:0] in_dat [8];

    assign in_dat[0] = in0;
    assign in_dat[1] = in1;
    assign in_dat[2] = in2;
    assign in_dat[3] = in3;
    assign in_dat[4] = in4;
    assign in_dat[5] = in5;
    assign in_dat[6] = in6;
    assign in_dat[7] = '0;

    logic [W-1:0] out_q,       out_d;
    logic [2:0]   out_sel_q,   out_sel_d;
    logic         out_valid_q, out_valid_d;

    logic [2:0]   search_start;
    logic [3:0]   idx;
    logic         gnt_vld;
    logic [2:0]   gnt_idx;
    logic         load_en;
    logic         xfer;

    // The output register can take a word when empty or while it drains.
    assign load_en = !out_valid_q || out_ready;
    assign xfer    = !rst && gnt_vld && load_en;

`ifdef FIXED_PRIO_EN
    assign search_start = 3'd0;
`else
    logic [2:0] rr_ptr_q, rr_ptr_d;

    assign search_start = rr_ptr_q;

    // Pointer moves just past the granted channel, wrapping 6 -> 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == 3'(NCH - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 3'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Search upward from search_start with wrap; the first requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 3'd0;
        idx     = 4'd0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, search_start} + k[3:0];
            if (idx >= 4'(NCH)) begin
                idx = idx - 4'(NCH);
            end
            if (!gnt_vld && in_valid[idx[2:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[2:0];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // EMPTY/FULL is carried by out_valid; a drain with no new word empties it,
    // a stall holds everything.
    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_d       = in_dat[gnt_idx];
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_sel_q   <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
